// File: rtl/systolic_pkg.sv
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared types and sizing helpers for the systolic array feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WLOAD  = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } feeder_state_t;

   localparam int DEF_DATAWIDTH = 8;
   localparam int PSUM_W        = DEF_DATAWIDTH * 4;

   // Drain counter must hold N_SIZE-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/skew_line.sv
// ============================================================================
// Module   : skew_line
// Purpose  : Enable-gated shift register of DEPTH stages, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else if (en) begin
         r_stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// Module   : systolic_feeder
// Purpose  : Skews activation vectors into the systolic array and sequences
//            the weight-load strobe. Optional column bias: SYSTOLIC_BIAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int N_SIZE    = 32
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wt_load,
   input  logic                                start,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                in_last,
   input  logic [N_SIZE-1:0][DATAWIDTH-1:0]    in_vec,
`ifdef SYSTOLIC_BIAS_EN
   input  logic [N_SIZE-1:0][DATAWIDTH*4-1:0]  bias_in,
`endif
   output logic [N_SIZE-1:0][DATAWIDTH-1:0]    matrix_A,
   output logic [N_SIZE-1:0][DATAWIDTH*4-1:0]  matrix_B,
   output logic                                valid_in,
   output logic                                wt_en,
   output logic                                busy,
   output logic                                done
);

   localparam int                 C_CNT_W      = cnt_width(N_SIZE);
   localparam logic [C_CNT_W-1:0] C_DRAIN_INIT = C_CNT_W'(N_SIZE - 1);

   feeder_state_t                    r_state, w_state_nxt;
   logic [C_CNT_W-1:0]               r_cnt, w_cnt_nxt;
   logic                             w_advance;
   logic                             w_done_nxt;
   logic                             r_valid_in, r_wt_en, r_done;
   logic [N_SIZE-1:0][DATAWIDTH-1:0] w_line_in;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_advance   = 1'b0;
      w_done_nxt  = 1'b0;
      in_ready    = 1'b0;
      case (r_state)
         IDLE: begin
            if (wt_load)    w_state_nxt = WLOAD;
            else if (start) w_state_nxt = STREAM;
         end
         WLOAD: w_state_nxt = IDLE;
         STREAM: begin
            in_ready  = 1'b1;
            w_advance = in_valid;
            if (in_valid && in_last) begin
               if (N_SIZE == 1) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = DRAIN;
                  w_cnt_nxt   = C_DRAIN_INIT;
               end
            end
         end
         DRAIN: begin
            w_advance = 1'b1;
            w_cnt_nxt = r_cnt - C_CNT_W'(1);
            if (r_cnt == C_CNT_W'(1)) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_valid_in <= 1'b0;
         r_wt_en    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_valid_in <= w_advance;
         r_wt_en    <= (r_state == IDLE) && wt_load;
         r_done     <= w_done_nxt;
      end
   end

   assign valid_in = r_valid_in;
   assign wt_en    = r_wt_en;
   assign done     = r_done;
   // The done cycle still belongs to the tile, so busy drops one cycle after it.
   assign busy     = (r_state != IDLE) || r_done;

   assign w_line_in = (r_state == DRAIN) ? '0 : in_vec;

   for (genvar k = 0; k < N_SIZE; k++) begin : g_row
      skew_line #(
         .WIDTH (DATAWIDTH),
         .DEPTH (k + 1)
      ) u_line (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (w_advance),
         .d     (w_line_in[k]),
         .q     (matrix_A[k])
      );
   end

`ifdef SYSTOLIC_BIAS_EN
   logic                                w_start_acc;
   logic [N_SIZE-1:0][DATAWIDTH*4-1:0]  r_bias;

   assign w_start_acc = (r_state == IDLE) && start && !wt_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_bias <= '0;
      else if (w_start_acc) r_bias <= bias_in;
   end

   assign matrix_B = r_bias;
`else
   assign matrix_B = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
// Module   : tb_systolic_feeder
// Purpose  : Scoreboard bench for systolic_feeder at N_SIZE=4, DATAWIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_feeder;

   localparam int DW = 8;
   localparam int N  = 4;

   logic                    clk      = 1'b0;
   logic                    rst_n    = 1'b0;
   logic                    wt_load  = 1'b0;
   logic                    start    = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_last  = 1'b0;
   logic [N-1:0][DW-1:0]    in_vec   = '0;
`ifdef SYSTOLIC_BIAS_EN
   logic [N-1:0][DW*4-1:0]  bias_in  = '0;
`endif
   logic                    in_ready;
   logic [N-1:0][DW-1:0]    matrix_A;
   logic [N-1:0][DW*4-1:0]  matrix_B;
   logic                    valid_in, wt_en, busy, done;

   systolic_feeder #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wt_load  (wt_load),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .in_vec   (in_vec),
`ifdef SYSTOLIC_BIAS_EN
      .bias_in  (bias_in),
`endif
      .matrix_A (matrix_A),
      .matrix_B (matrix_B),
      .valid_in (valid_in),
      .wt_en    (wt_en),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int                      n_cmp   = 0;
   int                      n_bad   = 0;
   int                      n_valid = 0;
   logic [31:0]             exp_a_q[$];
   logic                    exp_d_q[$];
   logic [N-1:0][DW*4-1:0]  exp_b = '0;
   logic [31:0]             mon_a;
   logic                    mon_d;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected array-side view for vectors {1,2,3,4} then {5,6,7,8}, packed {A3,A2,A1,A0}.
   task automatic push_tile();
      exp_a_q.push_back(32'h00_00_00_01); exp_d_q.push_back(1'b0);
      exp_a_q.push_back(32'h00_00_02_05); exp_d_q.push_back(1'b0);
      exp_a_q.push_back(32'h00_03_06_00); exp_d_q.push_back(1'b0);
      exp_a_q.push_back(32'h04_07_00_00); exp_d_q.push_back(1'b0);
      exp_a_q.push_back(32'h08_00_00_00); exp_d_q.push_back(1'b1);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_in) begin
            n_valid++;
            if (exp_a_q.size() == 0) begin
               check("unexpected valid_in", 1, 0);
            end else begin
               mon_a = exp_a_q.pop_front();
               mon_d = exp_d_q.pop_front();
               check("matrix_A", matrix_A, mon_a);
               check("done at valid", done, mon_d);
               check("matrix_B", matrix_B, exp_b);
            end
         end else begin
            check("done without valid_in", done, 0);
         end
      end
   end

   task automatic feed_tile(input int bubbles);
      n_valid = 0;
      push_tile();
      @(posedge clk); #1;
      start = 1'b1;
`ifdef SYSTOLIC_BIAS_EN
      bias_in = {32'd40, 32'd30, 32'd20, 32'd10};
      exp_b   = {32'd40, 32'd30, 32'd20, 32'd10};
`endif
      @(posedge clk); #1;
      start = 1'b0;
`ifdef SYSTOLIC_BIAS_EN
      bias_in = {32'd4, 32'd3, 32'd2, 32'd1};
`endif
      check("in_ready after start", in_ready, 1);
      check("busy in stream", busy, 1);
      in_valid = 1'b1;
      in_vec   = 32'h04_03_02_01;
      @(posedge clk); #1;
      if (bubbles > 0) begin
         in_valid = 1'b0;
         repeat (bubbles) begin
            @(posedge clk); #1;
            check("stall valid_in", valid_in, 0);
            check("stall matrix_A frozen", matrix_A, 32'h00_00_00_01);
         end
      end
      in_valid = 1'b1;
      in_vec   = 32'h08_07_06_05;
      in_last  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_vec   = '0;
      check("in_ready in drain", in_ready, 0);
   endtask

   task automatic run_tile(input int bubbles);
      bit seen;
      feed_tile(bubbles);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("done seen", seen, 1);
      if (seen) begin
         check("busy in done cycle", busy, 1);
         @(posedge clk); #1;
         check("busy after done", busy, 0);
         check("done one cycle", done, 0);
      end
      check("valid_in cycles", n_valid, 5);
      check("scoreboard drained", exp_a_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset matrix_A", matrix_A, 0);
      check("reset matrix_B", matrix_B, 0);
      check("reset valid_in", valid_in, 0);
      check("reset wt_en", wt_en, 0);
      check("reset done", done, 0);
      check("reset busy", busy, 0);
      check("reset in_ready", in_ready, 0);
      rst_n = 1'b1;

      // Weight load alone
      @(posedge clk); #1;
      wt_load = 1'b1;
      @(posedge clk); #1;
      wt_load = 1'b0;
      check("wt_en pulse", wt_en, 1);
      check("busy in wload", busy, 1);
      check("in_ready in wload", in_ready, 0);
      @(posedge clk); #1;
      check("wt_en single cycle", wt_en, 0);
      check("busy after wload", busy, 0);

      run_tile(0);
      run_tile(2);

      // wt_load and start together: start is dropped
      @(posedge clk); #1;
      wt_load = 1'b1;
      start   = 1'b1;
      @(posedge clk); #1;
      wt_load = 1'b0;
      start   = 1'b0;
      check("collide wt_en", wt_en, 1);
      check("collide in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("collide wt_en off", wt_en, 0);
      check("collide busy off", busy, 0);
      check("collide in_ready idle", in_ready, 0);
      @(posedge clk); #1;
      check("collide no valid_in", valid_in, 0);

      // Reset during drain
      feed_tile(0);
      @(posedge clk); #1;
      #1 rst_n = 1'b0;
      #1;
      check("rst matrix_A", matrix_A, 0);
      check("rst matrix_B", matrix_B, 0);
      check("rst valid_in", valid_in, 0);
      check("rst done", done, 0);
      check("rst busy", busy, 0);
      check("rst in_ready", in_ready, 0);
      exp_a_q.delete();
      exp_d_q.delete();
      @(posedge clk); #1;
      check("rst held done", done, 0);
      #1 rst_n = 1'b1;
      run_tile(0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
